// File: rtl/pipe_shifter_if.sv
// Handshake/data bundle for pipe_shifter: producer-side input channel plus consumer-side result channel.
interface pipe_shifter_if #(
   parameter int WIDTH = 32
);
   localparam int SW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic [SW-1:0]    shamt;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             zero;

   modport master (
      output in_valid, din, shamt, op, out_ready,
      input  in_ready, out_valid, dout, zero
   );

   modport slave (
      input  in_valid, din, shamt, op, out_ready,
      output in_ready, out_valid, dout, zero
   );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with valid/ready flow control.
// Macro PIPE_SHIFTER_ROT_EN enables rotates; without it op 011/100 pass din through.
module pipe_shifter #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   pipe_shifter_if.slave bus
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int SW     = LEVELS;
   localparam int BASE   = LEVELS / STAGES;
   localparam int REM    = LEVELS % STAGES;

   // First mux level owned by stage s; earlier stages absorb the remainder.
   function automatic int lvl_lo(input int s);
      return s * BASE + ((s < REM) ? s : REM);
   endfunction

   function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                  input logic [2:0] o, input int k);
      logic [WIDTH-1:0] r;
      r = d;
      case (o)
         3'b000:  r = d << (1 << k);
         3'b001:  r = d >> (1 << k);
         3'b010:  r = $signed(d) >>> (1 << k);
`ifdef PIPE_SHIFTER_ROT_EN
         3'b011:  r = (d << (1 << k)) | (d >> (WIDTH - (1 << k)));
         3'b100:  r = (d >> (1 << k)) | (d << (WIDTH - (1 << k)));
`else
         3'b011,
         3'b100:  r = d;
`endif
         default: r = d;
      endcase
      return r;
   endfunction

   logic [STAGES-1:0]            vld_pipe;
   logic [STAGES-1:0][WIDTH-1:0] dat_q;
   logic [STAGES-1:0][WIDTH-1:0] dat_c;
   logic [STAGES-1:0][SW-1:0]    sh_q;
   logic [STAGES-1:0][2:0]       op_q;
   logic                         adv;

   assign adv           = !vld_pipe[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = adv || rst;
   assign bus.out_valid = vld_pipe[STAGES-1];
   assign bus.dout      = dat_c[STAGES-1];
   assign bus.zero      = vld_pipe[STAGES-1] && (dat_c[STAGES-1] == '0);

   for (genvar s = 0; s < STAGES; s++) begin : g_stg
      localparam int LO = lvl_lo(s);
      localparam int HI = lvl_lo(s + 1);

      logic             v_in;
      logic [WIDTH-1:0] d_in;
      logic [SW-1:0]    s_in;
      logic [2:0]       o_in;

      if (s == 0) begin : g_head
         assign v_in = bus.in_valid;
         assign d_in = bus.din;
         assign s_in = bus.shamt;
         assign o_in = bus.op;
      end else begin : g_body
         assign v_in = vld_pipe[s-1];
         assign d_in = dat_c[s-1];
         assign s_in = sh_q[s-1];
         assign o_in = op_q[s-1];
      end

      // Register first, then this stage's mux levels; the last stage's mux drives dout.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_pipe[s] <= 1'b0;
            dat_q[s]    <= '0;
            sh_q[s]     <= '0;
            op_q[s]     <= '0;
         end else if (adv) begin
            vld_pipe[s] <= v_in;
            dat_q[s]    <= d_in;
            sh_q[s]     <= s_in;
            op_q[s]     <= o_in;
         end
      end

      logic [HI-LO:0][WIDTH-1:0] chain;
      assign chain[0] = dat_q[s];
      for (genvar k = LO; k < HI; k++) begin : g_lvl
         assign chain[k-LO+1] = sh_q[s][k] ? shift_lvl(chain[k-LO], op_q[s], k) : chain[k-LO];
      end
      assign dat_c[s] = chain[HI-LO];

      if (s == STAGES - 1) begin : g_tail
         logic sh_unused;
         assign sh_unused = ^sh_q[s];
      end
   end
endmodule

// File: tb/tb_pipe_shifter.sv
// Directed and reference-model bench for pipe_shifter at STAGES = 2, 1 and 5.
module tb_pipe_shifter;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipe_shifter_if #(.WIDTH(32)) i2 ();
   pipe_shifter_if #(.WIDTH(32)) i1 ();
   pipe_shifter_if #(.WIDTH(32)) i5 ();

   pipe_shifter #(.WIDTH(32), .STAGES(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
   pipe_shifter #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
   pipe_shifter #(.WIDTH(32), .STAGES(5)) u5 (.clk(clk), .rst(rst), .bus(i5));

   function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] o, input int sh);
      logic [31:0] r;
      logic        rot;
`ifdef PIPE_SHIFTER_ROT_EN
      rot = 1'b1;
`else
      rot = 1'b0;
`endif
      r = d;
      for (int i = 0; i < 32; i++) begin
         case (o)
            3'd0: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
            3'd1: r[i] = (i + sh < 32) ? d[i+sh] : 1'b0;
            3'd2: r[i] = (i + sh < 32) ? d[i+sh] : d[31];
            3'd3: if (rot) r[i] = d[(i - sh + 32) % 32];
            3'd4: if (rot) r[i] = d[(i + sh) % 32];
            default: ;
         endcase
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", i2.out_valid); end
      total++; if (i2.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", i2.in_ready); end
      total++; if (i2.dout !== 32'h0) begin bad++; $display("FAIL rst_dout: got %h want 0", i2.dout); end
      total++; if (i2.zero !== 1'b0) begin bad++; $display("FAIL rst_zero: got %b want 0", i2.zero); end
      rst = 1'b0;
      tick();
      total++; if (i2.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", i2.in_ready); end
      total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid: got %b want 0", i2.out_valid); end
   endtask

   task automatic test_directed;
      logic [31:0] t_din [7];
      logic [4:0]  t_sh  [7];
      logic [2:0]  t_op  [7];
      logic [31:0] t_exp [7];
      t_din[0] = 32'h80000010; t_sh[0] = 5'd4;  t_op[0] = 3'b010; t_exp[0] = 32'hF8000001;
      t_din[1] = 32'h0000000F; t_sh[1] = 5'd4;  t_op[1] = 3'b100;
`ifdef PIPE_SHIFTER_ROT_EN
      t_exp[1] = 32'hF0000000;
`else
      t_exp[1] = 32'h0000000F;
`endif
      t_din[2] = 32'h80000000; t_sh[2] = 5'd1;  t_op[2] = 3'b000; t_exp[2] = 32'h00000000;
      t_din[3] = 32'hFFFFFFFF; t_sh[3] = 5'd31; t_op[3] = 3'b001; t_exp[3] = 32'h00000001;
      t_din[4] = 32'hDEADBEEF; t_sh[4] = 5'd5;  t_op[4] = 3'b111; t_exp[4] = 32'hDEADBEEF;
      t_din[5] = 32'h12345678; t_sh[5] = 5'd0;  t_op[5] = 3'b011; t_exp[5] = 32'h12345678;
      t_din[6] = 32'h00000000; t_sh[6] = 5'd9;  t_op[6] = 3'b110; t_exp[6] = 32'h00000000;
      for (int n = 0; n < 7; n++) begin
         i2.in_valid = 1'b1; i2.din = t_din[n]; i2.shamt = t_sh[n]; i2.op = t_op[n]; i2.out_ready = 1'b1;
         tick();
         i2.in_valid = 1'b0;
         total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid: got %b want 0", n, i2.out_valid); end
         tick();
         total++; if (i2.out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid: got %b want 1", n, i2.out_valid); end
         total++; if (i2.dout !== t_exp[n]) begin bad++; $display("FAIL dir%0d_dout: got %h want %h", n, i2.dout, t_exp[n]); end
         total++; if (i2.zero !== (t_exp[n] == 32'h0)) begin bad++; $display("FAIL dir%0d_zero: got %b want %b", n, i2.zero, t_exp[n] == 32'h0); end
         tick();
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'd2; exp_seq[1] = 32'd4; exp_seq[2] = 32'd6;
      i2.op = 3'b000; i2.shamt = 5'd1; i2.out_ready = 1'b1;
      i2.in_valid = 1'b1; i2.din = 32'd1;
      #1;
      total++; if (i2.in_ready !== 1'b1) begin bad++; $display("FAIL bp_c0_in_ready: got %b want 1", i2.in_ready); end
      tick();
      i2.din = 32'd2;
      #1;
      total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL bp_c1_out_valid: got %b want 0", i2.out_valid); end
      tick();
      i2.din = 32'd3; i2.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (i2.out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall%0d_valid: got %b want 1", c, i2.out_valid); end
         total++; if (i2.dout !== 32'd2) begin bad++; $display("FAIL bp_stall%0d_dout: got %h want 2", c, i2.dout); end
         total++; if (i2.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall%0d_in_ready: got %b want 0", c, i2.in_ready); end
         tick();
      end
      i2.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (i2.out_valid !== 1'b1) begin bad++; $display("FAIL bp_drain%0d_valid: got %b want 1", c, i2.out_valid); end
         total++; if (i2.dout !== exp_seq[c]) begin bad++; $display("FAIL bp_drain%0d_dout: got %h want %h", c, i2.dout, exp_seq[c]); end
         tick();
         i2.in_valid = 1'b0;
      end
      total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", i2.out_valid); end
   endtask

   task automatic test_reset_midflight;
      i2.out_ready = 1'b1; i2.op = 3'b001; i2.shamt = 5'd1;
      i2.in_valid = 1'b1; i2.din = 32'h10;
      tick();
      i2.din = 32'h20;
      tick();
      rst = 1'b1; i2.din = 32'h30;
      #1;
      total++; if (i2.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", i2.in_ready); end
      tick();
      rst = 1'b0; i2.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++; if (i2.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_drop%0d: got %b want 0", c, i2.out_valid); end
         tick();
      end
   endtask

   task automatic test_stages_random;
      localparam int N = 40;
      logic [31:0] ed [N];
      logic [31:0] d;
      logic [2:0]  o;
      logic [4:0]  s;
      i1.out_ready = 1'b1; i5.out_ready = 1'b1;
      for (int i = 0; i < N + 5; i++) begin
         if (i < N) begin
            d = $urandom;
            o = 3'($urandom_range(0, 7));
            s = 5'($urandom_range(0, 31));
            if (i % 9 == 0) d = 32'h0;
            ed[i] = model(d, o, int'(s));
            i1.in_valid = 1'b1; i1.din = d; i1.op = o; i1.shamt = s;
            i5.in_valid = 1'b1; i5.din = d; i5.op = o; i5.shamt = s;
            #1;
            total++; if (i5.in_ready !== 1'b1) begin bad++; $display("FAIL s5_in_ready%0d: got %b want 1", i, i5.in_ready); end
         end else begin
            i1.in_valid = 1'b0; i5.in_valid = 1'b0;
            #1;
         end
         if (i >= 1 && i <= N) begin
            total++; if (i1.out_valid !== 1'b1 || i1.dout !== ed[i-1]) begin bad++; $display("FAIL s1_res%0d: got v=%b %h want v=1 %h", i - 1, i1.out_valid, i1.dout, ed[i-1]); end
         end else begin
            total++; if (i1.out_valid !== 1'b0) begin bad++; $display("FAIL s1_idle%0d: got %b want 0", i, i1.out_valid); end
         end
         if (i >= 5 && i <= N + 4) begin
            total++; if (i5.out_valid !== 1'b1 || i5.dout !== ed[i-5]) begin bad++; $display("FAIL s5_res%0d: got v=%b %h want v=1 %h", i - 5, i5.out_valid, i5.dout, ed[i-5]); end
            total++; if (i5.zero !== (ed[i-5] == 32'h0)) begin bad++; $display("FAIL s5_zero%0d: got %b want %b", i - 5, i5.zero, ed[i-5] == 32'h0); end
         end else begin
            total++; if (i5.out_valid !== 1'b0) begin bad++; $display("FAIL s5_idle%0d: got %b want 0", i, i5.out_valid); end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      i2.in_valid = 1'b0; i2.din = '0; i2.shamt = '0; i2.op = '0; i2.out_ready = 1'b1;
      i1.in_valid = 1'b0; i1.din = '0; i1.shamt = '0; i1.op = '0; i1.out_ready = 1'b1;
      i5.in_valid = 1'b0; i5.din = '0; i5.shamt = '0; i5.op = '0; i5.out_ready = 1'b1;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
      test_stages_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
